// File: rtl/shifter_pkg.sv
// Shared op encodings and status-flag layout for the shared shift datapath.
package shifter_pkg;

  localparam logic [1:0] SHIFT_SRA     = 2'b00;
  localparam logic [1:0] SHIFT_SRL     = 2'b01;
  localparam logic [1:0] SHIFT_SLL     = 2'b10;
  localparam logic [1:0] SHIFT_SLL_ALT = 2'b11;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/shift_core.sv
// 32-bit barrel shifter with status flags; purely combinational.
// No state, no handshake: result and flags follow op/amt/data directly.
module shift_core
  import shifter_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [4:0]  amt,
  input  logic [31:0] data,
  output logic [31:0] result,
  output flags_t      flags
);

  logic [4:0] rsel;
  logic [4:0] lsel;
  logic       carry;

  // Last bit shifted out: data[amt-1] going right, data[32-amt] going left (mod 32).
  assign rsel = amt - 5'd1;
  assign lsel = 5'd0 - amt;

  always_comb begin
    result = data;
    carry  = 1'b0;
    case (op)
      SHIFT_SRA: begin
        result = 32'($signed(data) >>> amt);
        carry  = (amt != 5'd0) && data[rsel];
      end
      SHIFT_SRL: begin
        result = data >> amt;
        carry  = (amt != 5'd0) && data[rsel];
      end
      SHIFT_SLL, SHIFT_SLL_ALT: begin
        result = data << amt;
        carry  = (amt != 5'd0) && data[lsel];
      end
    endcase
  end

  assign flags.zero     = (result == 32'd0);
  assign flags.carry    = carry;
  assign flags.negative = result[31];
  assign flags.overflow = 1'b0;

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one shift_core among NUM_REQ requesters; result registered, 1-cycle latency.
// Single-entry output slot: grants only when the slot is empty or draining; outputs hold while stalled.
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [5*NUM_REQ-1:0]    req_amt,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [31:0]             resp_result,
  output logic                    resp_zero,
  output logic                    resp_carry,
  output logic                    resp_negative,
  output logic                    resp_overflow
);

  logic            slot_free;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] gid;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] ptr;

  logic [1:0]      op_arr   [NUM_REQ];
  logic [4:0]      amt_arr  [NUM_REQ];
  logic [31:0]     data_arr [NUM_REQ];

  logic [31:0]     sh_result;
  flags_t          sh_flags;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]   = req_op[2*i +: 2];
    assign amt_arr[i]  = req_amt[5*i +: 5];
    assign data_arr[i] = req_data[32*i +: 32];
  end

  assign slot_free = !resp_valid || resp_ready;

  // Search upward from ptr; the grant itself never looks at op/amt/data.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end

  assign grant = found && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gid] = 1'b1;
  end

  shift_core u_shift_core (
    .op     (op_arr[gid]),
    .amt    (amt_arr[gid]),
    .data   (data_arr[gid]),
    .result (sh_result),
    .flags  (sh_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_carry    <= 1'b0;
      resp_negative <= 1'b0;
      resp_overflow <= 1'b0;
      ptr           <= '0;
    end else if (grant) begin
      resp_valid    <= 1'b1;
      resp_id       <= gid;
      resp_result   <= sh_result;
      resp_zero     <= sh_flags.zero;
      resp_carry    <= sh_flags.carry;
      resp_negative <= sh_flags.negative;
      resp_overflow <= sh_flags.overflow;
      ptr           <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + ID_W'(1);
    end else if (resp_ready) begin
      resp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed vectors, corner sequences, randomized traffic vs model.
module tb_shifter_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [5*N-1:0]  req_amt;
  logic [32*N-1:0] req_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [31:0]     resp_result;
  logic            resp_zero, resp_carry, resp_negative, resp_overflow;

  shifter_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amt(req_amt), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_carry(resp_carry),
    .resp_negative(resp_negative), .resp_overflow(resp_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the output slot and priority pointer.
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_res   = 32'd0;
  logic [3:0]  m_fl    = 4'd0;
  int          last_grant;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] res;
    logic [3:0]  fl;   // {zero, carry, negative, overflow}
  } vec_t;

  vec_t tbl[10];
  int   wait_cnt[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift via 64-bit widening: bits leaving the word land in a visible position.
  function automatic void ref_shift(input logic [1:0] op, input int s, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] fl);
    logic [63:0] w;
    logic        c;
    if (op[1]) begin
      w = {32'd0, b} << s;
      r = w[31:0];
      c = w[32];
    end else begin
      w = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
      r = 32'(w >> s);
      c = (s == 0) ? 1'b0 : w[s-1];
    end
    fl = {(r == 32'd0), c, r[31], 1'b0};
  endfunction

  // Winner is the valid requester at the smallest circular distance from ptr.
  function automatic int model_grant();
    int best, bd, d;
    best = -1;
    bd   = N;
    if (rst || (m_valid && !resp_ready)) return -1;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (req_valid[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [4:0] amt, input logic [31:0] d);
    req_valid[i]          = v;
    req_op[i*2 +: 2]      = op;
    req_amt[i*5 +: 5]     = amt;
    req_data[i*32 +: 32]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  // Called just after a rising edge with inputs already applied; advances one cycle.
  task automatic run_cycle(input string tag);
    int          g;
    logic [N-1:0] exp_rdy;
    logic [31:0] r;
    logic [3:0]  fl;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    last_grant = g;
    r  = 32'd0;
    fl = 4'd0;
    if (g >= 0) ref_shift(req_op[g*2 +: 2], int'(req_amt[g*5 +: 5]), req_data[g*32 +: 32], r, fl);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_id = 0; m_res = 32'd0; m_fl = 4'd0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_id = g; m_res = r; m_fl = fl; m_ptr = (g + 1) % N;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(m_valid));
    chk({tag, ".resp_id"}, 32'(resp_id), 32'(m_id));
    chk({tag, ".resp_result"}, resp_result, m_res);
    chk({tag, ".flags"}, 32'({resp_zero, resp_carry, resp_negative, resp_overflow}), 32'(m_fl));
  endtask

  initial begin
    int exp_ids[6];
    tbl[0] = '{2'b00, 5'd4,  32'h8000_00F0, 32'hF800_000F, 4'b0010};
    tbl[1] = '{2'b10, 5'd1,  32'h8000_0000, 32'h0000_0000, 4'b1100};
    tbl[2] = '{2'b01, 5'd0,  32'h0000_0001, 32'h0000_0001, 4'b0000};
    tbl[3] = '{2'b11, 5'd4,  32'h1234_5678, 32'h2345_6780, 4'b0100};
    tbl[4] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100};
    tbl[5] = '{2'b00, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 4'b1100};
    tbl[6] = '{2'b00, 5'd1,  32'h0000_0003, 32'h0000_0001, 4'b0100};
    tbl[7] = '{2'b10, 5'd31, 32'h0000_0003, 32'h8000_0000, 4'b0110};
    tbl[8] = '{2'b01, 5'd16, 32'h0000_8000, 32'h0000_0000, 4'b1100};
    tbl[9] = '{2'b00, 5'd0,  32'h8000_0000, 32'h8000_0000, 4'b0010};
    exp_ids = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1;
    resp_ready = 1'b1;
    req_valid = '0; req_op = '0; req_amt = '0; req_data = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles
    run_cycle("reset0");
    run_cycle("reset1");
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.resp_result", resp_result, 32'd0);
    rst = 1'b0;

    // Directed vectors on requester 0 (lone requester, consecutive grants)
    foreach (tbl[v]) begin
      set_req(0, 1'b1, tbl[v].op, tbl[v].amt, tbl[v].data);
      run_cycle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d.tbl_result", v), resp_result, tbl[v].res);
      chk($sformatf("vec%0d.tbl_flags", v),
          32'({resp_zero, resp_carry, resp_negative, resp_overflow}), 32'(tbl[v].fl));
      chk($sformatf("vec%0d.tbl_id", v), 32'(resp_id), 32'd0);
    end

    // Round-robin rotation from a fresh pointer
    clear_reqs();
    rst = 1'b1;
    run_cycle("rr_rst");
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b10, 5'(i), 32'h0000_0100 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      run_cycle("rr");
      chk($sformatf("rr_id%0d", c), 32'(resp_id), 32'(exp_ids[c]));
    end

    // Back-pressure: slot held by requester 1 while requester 2 waits
    clear_reqs();
    resp_ready = 1'b0;
    rst = 1'b1;
    run_cycle("bp_rst");
    rst = 1'b0;
    set_req(1, 1'b1, 2'b01, 5'd8, 32'hABCD_0000);
    run_cycle("bp_fill");
    set_req(1, 1'b0, 2'b00, 5'd0, 32'd0);
    set_req(2, 1'b1, 2'b10, 5'd4, 32'h0000_00F1);
    for (int c = 0; c < 3; c++) begin
      run_cycle("bp_stall");
      chk("bp_stall.req_ready_zero", 32'(req_ready), 32'd0);
      chk("bp_stall.held_result", resp_result, 32'h00AB_CD00);
      chk("bp_stall.held_id", 32'(resp_id), 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release.req_ready", 32'(req_ready), 32'b0100);
    run_cycle("bp_release");
    chk("bp_release.result", resp_result, 32'h0000_0F10);
    chk("bp_release.id", 32'(resp_id), 32'd2);

    // Reset while the slot is full and two requests wait
    set_req(2, 1'b0, 2'b00, 5'd0, 32'd0);
    resp_ready = 1'b0;
    set_req(1, 1'b1, 2'b00, 5'd3, 32'hF000_0000);
    set_req(3, 1'b1, 2'b01, 5'd3, 32'h0000_0080);
    rst = 1'b1;
    run_cycle("mid_rst");
    chk("mid_rst.resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    resp_ready = 1'b1;
    set_req(0, 1'b1, 2'b10, 5'd2, 32'h0000_0001);
    #1;
    chk("post_rst.req_ready", 32'(req_ready), 32'b0001);
    run_cycle("post_rst");
    chk("post_rst.id", 32'(resp_id), 32'd0);
    chk("post_rst.result", resp_result, 32'h0000_0004);

    // Randomized traffic; requesters hold their request until granted
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      logic was_rst;
      was_rst = rst;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_grant != i))
          set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      if (was_rst) for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      run_cycle("rand");
      for (int i = 0; i < N; i++) begin
        if (rst) wait_cnt[i] = 0;
        else if (last_grant == i) begin
          chk($sformatf("fair%0d", i), 32'(wait_cnt[i] < N), 32'd1);
          wait_cnt[i] = 0;
        end else if (last_grant >= 0 && req_valid[i]) wait_cnt[i]++;
        else if (!req_valid[i]) wait_cnt[i] = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
# shifter_arbiter

Round-robin arbiter and pipeline stage that shares one 32-bit barrel-shift datapath among `NUM_REQ` requesters, such as the integer pipe, the address-generation unit and a multi-cycle multiply/divide sequencer. Each requester presents an op, amount and operand under a valid/ready handshake. The block grants at most one requester per cycle, computes the shift combinationally and registers the result, four status flags and the winner's ID into a single-entry output slot with its own valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of the requester ID; must equal max(1, ceil(log2(NUM_REQ))).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant; one-hot or zero.
- `req_op`  in  2*NUM_REQ  per-requester op, {aluc1,aluc0}: 00 SRA, 01 SRL, 10 SLL, 11 SLL.
- `req_amt`  in  5*NUM_REQ  per-requester shift amount.
- `req_data`  in  32*NUM_REQ  per-requester operand being shifted.
- `resp_valid`  out  1  output slot holds a result.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  ID_W  index of the requester that produced the result.
- `resp_result`  out  32  shifted value.
- `resp_zero`, `resp_carry`, `resp_negative`, `resp_overflow`  out  1 each  status flags.

## Operation
- **Slot free condition:** `slot_free = !resp_valid || resp_ready`.
- **Grant:**
  - When `slot_free` is true, grant the first asserted `req_valid` found by searching upward from the priority pointer `ptr`, wrapping modulo `NUM_REQ`.
  - Assert `req_ready` only for that requester.
  - When `slot_free` is false, `req_ready` is all zeros.
- **Grant independence:** `req_ready[i]` depends on `req_valid`, `ptr`, `resp_valid` and `resp_ready` only. It never depends on that requester's op, amount or data.
- **Pointer update:** on a grant to requester g, `ptr <= (g+1) mod NUM_REQ`. With no grant, `ptr` holds.
- **Shift semantics** (s = amt, B = data):
  - SRA: result = B arithmetically shifted right by s; carry = B[s-1].
  - SRL: result = B logically shifted right by s; carry = B[s-1].
  - SLL: result = B << s; carry = B[32-s].
  - s = 0: carry = 0 for every op, and result = B.
  - zero = (result == 0).
  - negative = result[31].
  - overflow = 0 always.
- **Capture:** on a grant, register the result, the four flags and ID g into the slot, and set `resp_valid`.
- **Drain:** if `resp_ready` is high and there is no grant in the same cycle, clear `resp_valid`.
- **Back-pressure:** while `resp_valid && !resp_ready`, all `resp_*` outputs hold stable.
- **Requester obligation:** requesters keep `req_*` stable while valid is high and not yet granted. The block does not check this.

## Timing
- **Latency:** a grant in cycle N produces `resp_valid` = 1 with the result in cycle N+1.
- **Throughput:** one result per cycle while `resp_ready` stays high. Accept and drain in the same cycle is required.
- **Reset:** `resp_valid` = 0, `resp_id` = 0, `resp_result` = 0, all flags = 0, `ptr` = 0. `req_ready` = 0 during the reset cycle.
- **Reset mid-operation:** a result held in the slot is discarded, and no grant is issued in the reset cycle.
- **Simultaneous requests:**
  - All requesters valid with the consumer always ready: grants rotate 0,1,…,NUM_REQ-1,0.
  - A lone requester is granted on consecutive cycles.
- **Fairness bound:** a continuously valid requester is granted within NUM_REQ grant opportunities.

## Structure
- **Package `shifter_pkg`:**
  - op encoding constants SHIFT_SRA=2'b00, SHIFT_SRL=2'b01, SHIFT_SLL=2'b10, SHIFT_SLL_ALT=2'b11;
  - a packed flag struct {zero, carry, negative, overflow}.
- **Sub-module `shift_core`:** purely combinational (op, amt, data) -> (result, flags), implementing the semantics above. The arbiter instantiates exactly one.
- **Arbiter logic:** round-robin priority search, pointer register and output slot, kept in `shifter_arbiter` itself.

## Test plan
- **Reset and single request:** hold `rst` 2 cycles, then req 0: SRA, amt 4, data 0x8000_00F0, `resp_ready` = 1.
  - `req_ready[0]` in the same cycle.
  - Next cycle: result 0xF800_000F, carry 0, negative 1, zero 0, `resp_id` 0.
- **Flag edges:**
  - SLL, amt 1, data 0x8000_0000 -> result 0, zero 1, carry 1.
  - SRL, amt 0, data 0x1 -> result 0x1, carry 0.
  - overflow is always 0.
- **Round-robin:** all 4 requesters valid continuously, `resp_ready` = 1 -> `resp_id` sequence 0,1,2,3,0,1 on consecutive cycles.
- **Back-pressure:**
  - `resp_ready` = 0 for 3 cycles with req 2 pending -> `resp_*` frozen, `req_ready` = 0.
  - Raising `resp_ready` drains the slot and grants req 2 in the same cycle.
- **Mid-operation reset:** assert `rst` while `resp_valid` = 1 with two requests pending -> next cycle `resp_valid` = 0 and `ptr` = 0. After release, req 0 wins if valid.
